// File: rtl/painterengine_gpu_pkg.sv
// Shared reader state encodings, AXI read constants and the burst address boundary.
package painterengine_gpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_DATA  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_ERROR = 3'd7
   } rd_state_t;

   localparam logic [1:0] RESP_OKAY      = 2'b00;
   localparam logic [1:0] BURST_INCR     = 2'b01;
   localparam logic [2:0] SIZE_4B        = 3'b010;
   localparam int         BOUNDARY_BYTES = 4096;

endpackage

// File: rtl/painterengine_gpu_burstcalc.sv
// Burst sizer: min(remaining words, MAX_BURST, words left before the address boundary).
// Latency: purely combinational.
// Backpressure: none; the parent registers the result when it enters ADDR.
module painterengine_gpu_burstcalc #(
   parameter int MAX_BURST      = 64,
   parameter int BOUNDARY_BYTES = painterengine_gpu_pkg::BOUNDARY_BYTES
) (
   input  logic [31:0]                         remaining,
   input  logic [$clog2(BOUNDARY_BYTES)-1:2]   addr_words,
   output logic [8:0]                          beats
);
   localparam int AW = $clog2(BOUNDARY_BYTES);
   localparam logic [AW-2:0] BND_WORDS = (AW-1)'(BOUNDARY_BYTES / 4);

   logic [AW-2:0] to_bnd;
   logic [8:0]    cap;

   always_comb begin
      to_bnd = BND_WORDS - {1'b0, addr_words};
      if (32'(to_bnd) < 32'(MAX_BURST)) cap = 9'(to_bnd);
      else                              cap = 9'(MAX_BURST);
      if (remaining < 32'(cap)) beats = 9'(remaining);
      else                      beats = cap;
   end

endmodule

// File: rtl/painterengine_gpu_memreader.sv
// AXI4 read master splitting a streamer session into boundary-safe INCR bursts.
// Latency: AR one cycle after session open or previous burst end; R beats forwarded combinationally.
// Backpressure: rready follows i_wire_data_next in DATA; forced high while draining.
module painterengine_gpu_memreader #(
   parameter int MAX_BURST      = 64,
   parameter int BOUNDARY_BYTES = painterengine_gpu_pkg::BOUNDARY_BYTES
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_resetn,
   input  logic        i_wire_enable,
   input  logic [31:0] i_wire_address,
   input  logic [31:0] i_wire_length,
   output logic        o_wire_done,
   output logic        o_wire_error,
   output logic [31:0] o_wire_data,
   output logic        o_wire_data_valid,
   input  logic        i_wire_data_next,
   output logic [2:0]  o_wire_state,
   output logic [31:0] m_axi_araddr,
   output logic [7:0]  m_axi_arlen,
   output logic [2:0]  m_axi_arsize,
   output logic [1:0]  m_axi_arburst,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rlast,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);
   import painterengine_gpu_pkg::*;

   localparam int AW = $clog2(BOUNDARY_BYTES);

   rd_state_t     state, state_nxt;
   logic [31:0]   cur_addr, remaining, araddr_q;
   logic [7:0]    arlen_q;
   logic [8:0]    beats_q, beat_cnt, calc_beats;
   logic [31:0]   calc_rem;
   logic [AW-1:2] calc_words;
   logic          outstanding, outstanding_nxt;
   logic          load_burst, ar_hs, r_hs;

   // In IDLE the first burst is sized straight from the request inputs.
   assign calc_rem   = (state == ST_IDLE) ? i_wire_length : remaining;
   assign calc_words = (state == ST_IDLE) ? i_wire_address[AW-1:2] : cur_addr[AW-1:2];

   painterengine_gpu_burstcalc #(
      .MAX_BURST      (MAX_BURST),
      .BOUNDARY_BYTES (BOUNDARY_BYTES)
   ) u_burstcalc (
      .remaining  (calc_rem),
      .addr_words (calc_words),
      .beats      (calc_beats)
   );

   assign ar_hs = (state == ST_ADDR) && m_axi_arready;
   assign r_hs  = m_axi_rvalid && m_axi_rready;

   always_comb begin
      state_nxt         = state;
      outstanding_nxt   = outstanding;
      load_burst        = 1'b0;
      m_axi_rready      = 1'b0;
      o_wire_data_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_wire_enable) begin
               if (i_wire_address[1:0] != 2'b00) state_nxt = ST_ERROR;
               else if (i_wire_length == 32'd0)  state_nxt = ST_DONE;
               else begin
                  state_nxt  = ST_ADDR;
                  load_burst = 1'b1;
               end
            end
         end
         ST_ADDR: begin
            if (m_axi_arready) state_nxt = i_wire_enable ? ST_DATA : ST_DRAIN;
         end
         ST_DATA: begin
            if (!i_wire_enable) begin
               m_axi_rready = 1'b1;
               if (m_axi_rvalid && m_axi_rlast) state_nxt = ST_IDLE;
               else                             state_nxt = ST_DRAIN;
            end else begin
               m_axi_rready = i_wire_data_next;
               if (m_axi_rvalid && i_wire_data_next) begin
                  if (m_axi_rresp != RESP_OKAY) begin
                     state_nxt       = ST_ERROR;
                     outstanding_nxt = !m_axi_rlast;
                  end else begin
                     o_wire_data_valid = 1'b1;
                     // rlast must coincide exactly with the last expected beat
                     if (m_axi_rlast != (beat_cnt == 9'd1)) begin
                        state_nxt       = ST_ERROR;
                        outstanding_nxt = !m_axi_rlast;
                     end else if (m_axi_rlast) begin
                        if (remaining == 32'd0) state_nxt = ST_DONE;
                        else begin
                           state_nxt  = ST_ADDR;
                           load_burst = 1'b1;
                        end
                     end
                  end
               end
            end
         end
         ST_DONE: begin
            if (!i_wire_enable) state_nxt = ST_IDLE;
         end
         ST_DRAIN: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid && m_axi_rlast) state_nxt = ST_IDLE;
         end
         ST_ERROR: begin
            m_axi_rready = outstanding;
            if (outstanding && m_axi_rvalid && m_axi_rlast) outstanding_nxt = 1'b0;
            if (!outstanding && !i_wire_enable) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state       <= ST_IDLE;
         outstanding <= 1'b0;
         cur_addr    <= 32'd0;
         remaining   <= 32'd0;
         araddr_q    <= 32'd0;
         arlen_q     <= 8'd0;
         beats_q     <= 9'd0;
         beat_cnt    <= 9'd0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         if (state == ST_IDLE && i_wire_enable) begin
            cur_addr  <= i_wire_address;
            remaining <= i_wire_length;
         end
         if (load_burst) begin
            araddr_q <= (state == ST_IDLE) ? i_wire_address : cur_addr;
            arlen_q  <= 8'(calc_beats - 9'd1);
            beats_q  <= calc_beats;
         end
         if (ar_hs) begin
            cur_addr  <= cur_addr + {21'd0, beats_q, 2'b00};
            remaining <= remaining - {23'd0, beats_q};
            beat_cnt  <= beats_q;
         end else if (r_hs && state == ST_DATA) begin
            beat_cnt <= beat_cnt - 9'd1;
         end
      end
   end

   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = SIZE_4B;
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arvalid = (state == ST_ADDR);
   assign o_wire_done   = (state == ST_DONE);
   assign o_wire_error  = (state == ST_ERROR);
   assign o_wire_data   = m_axi_rdata;
   assign o_wire_state  = state;

endmodule

// File: tb/tb_painterengine_gpu_memreader.sv
// Bench for the AXI frame reader: table of sessions against a one-burst AXI slave model,
// plus hand sequences for reset, enable drop during ADDR and back-to-back sessions.
module tb_painterengine_gpu_memreader;
   import painterengine_gpu_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_wire_enable, i_wire_data_next;
   logic [31:0] i_wire_address, i_wire_length;
   logic        o_wire_done, o_wire_error, o_wire_data_valid;
   logic [31:0] o_wire_data;
   logic [2:0]  o_wire_state;
   logic [31:0] m_axi_araddr, m_axi_rdata;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst, m_axi_rresp;
   logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;

   always #5 clk = ~clk;

   painterengine_gpu_memreader #(.MAX_BURST(64)) dut (
      .i_wire_clock(clk), .i_wire_resetn(rstn), .i_wire_enable(i_wire_enable),
      .i_wire_address(i_wire_address), .i_wire_length(i_wire_length),
      .o_wire_done(o_wire_done), .o_wire_error(o_wire_error), .o_wire_data(o_wire_data),
      .o_wire_data_valid(o_wire_data_valid), .i_wire_data_next(i_wire_data_next),
      .o_wire_state(o_wire_state), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] len;
      bit          tog;
      int          err_beat;
      int          drop_at;
      int          n_ar;
      logic [31:0] a0;
      logic [7:0]  l0;
      logic [31:0] a1;
      logic [7:0]  l1;
      int          fwd;
      int          hs;
      bit          done;
      bit          err;
   } vec_t;

   vec_t vecs[10];

   int n_chk = 0, n_err = 0, cyc = 0;
   bit en = 0, dn_mode = 0, ar_block = 0;
   int err_beat = 0;
   logic [31:0] exp_addr;
   // slave model and per-session observations
   bit burst_act = 0;
   int blen = 0, bidx = 0;
   logic [31:0] baddr = 32'd0;
   logic [31:0] ar_a[4];
   logic [7:0]  ar_l[4];
   int n_ar, n_fwd, n_hs, data_bad, rr_bad, lat, t_hs;
   bit saw_done, saw_err, seen_end;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr();
      n_ar = 0; n_fwd = 0; n_hs = 0; data_bad = 0; rr_bad = 0;
      saw_done = 0; saw_err = 0; seen_end = 0; lat = -1; t_hs = cyc + 1;
      err_beat = 0; dn_mode = 0; ar_block = 0;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      i_wire_enable    = en;
      i_wire_data_next = dn_mode ? cyc[0] : 1'b1;
      m_axi_arready    = !ar_block;
      m_axi_rvalid     = burst_act;
      m_axi_rdata      = baddr + 32'(bidx) * 32'd4;
      m_axi_rlast      = burst_act && (bidx == blen - 1);
      m_axi_rresp      = (burst_act && (n_hs + 1 == err_beat)) ? 2'b10 : 2'b00;
      #1;
      if (o_wire_done)  saw_done = 1;
      if (o_wire_error) saw_err = 1;
      if ((o_wire_done || o_wire_error) && !seen_end) begin
         seen_end = 1;
         lat = cyc - t_hs;
      end
      if (o_wire_state == ST_DATA && i_wire_enable && m_axi_rready !== i_wire_data_next) rr_bad++;
      if (o_wire_state == ST_DRAIN && m_axi_rready !== 1'b1) rr_bad++;
      if (o_wire_data_valid) begin
         if (o_wire_data !== exp_addr + 32'(n_fwd) * 32'd4) data_bad++;
         n_fwd++;
      end
      if (m_axi_rvalid && m_axi_rready) begin
         n_hs++; t_hs = cyc; bidx++;
         if (bidx == blen) burst_act = 0;
      end
      if (m_axi_arvalid && m_axi_arready) begin
         if (n_ar < 4) begin ar_a[n_ar] = m_axi_araddr; ar_l[n_ar] = m_axi_arlen; end
         n_ar++;
         burst_act = 1; blen = int'(m_axi_arlen) + 1; bidx = 0; baddr = m_axi_araddr;
      end
   endtask

   task automatic close_session(input string tag);
      bit ok = 0;
      en = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (o_wire_state == ST_IDLE) begin ok = 1; break; end
      end
      chk({tag, "_idle"}, ok, 1);
      chk({tag, "_done_clr"}, o_wire_done, 0);
      chk({tag, "_err_clr"}, o_wire_error, 0);
   endtask

   task automatic run_row(input int r);
      vec_t v = vecs[r];
      bit fin = 0;
      int hold_bad = 0;
      logic d, e;
      string tag = $sformatf("row%0d", r);
      clr();
      dn_mode = v.tog; err_beat = v.err_beat; exp_addr = v.addr;
      i_wire_address = v.addr; i_wire_length = v.len; en = 1;
      for (int k = 0; k < 3000; k++) begin
         step();
         if (v.drop_at != 0 && n_fwd >= v.drop_at) en = 0;
         if (v.drop_at != 0) begin
            if (!en && o_wire_state == ST_IDLE && !burst_act) begin fin = 1; break; end
         end else if ((o_wire_done || o_wire_error) && !burst_act) begin
            fin = 1; break;
         end
      end
      chk({tag, "_finish"}, fin, 1);
      chk({tag, "_n_ar"}, n_ar, v.n_ar);
      if (v.n_ar > 0) begin chk({tag, "_ar0_addr"}, ar_a[0], v.a0); chk({tag, "_ar0_len"}, ar_l[0], v.l0); end
      if (v.n_ar > 1) begin chk({tag, "_ar1_addr"}, ar_a[1], v.a1); chk({tag, "_ar1_len"}, ar_l[1], v.l1); end
      chk({tag, "_fwd"}, n_fwd, v.fwd);
      chk({tag, "_hs"}, n_hs, v.hs);
      chk({tag, "_data"}, data_bad, 0);
      chk({tag, "_rready"}, rr_bad, 0);
      chk({tag, "_done"}, saw_done, v.done);
      chk({tag, "_error"}, saw_err, v.err);
      if (v.drop_at == 0) begin
         chk({tag, "_latency"}, lat, 1);
         d = o_wire_done; e = o_wire_error;
         repeat (3) begin
            step();
            if (o_wire_done !== d || o_wire_error !== e) hold_bad++;
         end
         chk({tag, "_hold"}, hold_bad, 0);
      end
      close_session(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad;
      bit ok;
      //       addr          len  tog err drop nar a0            l0  a1            l1  fwd  hs  done err
      vecs[0] = '{32'h1000_0000, 48, 0, 0, 0, 1, 32'h1000_0000, 47, 32'h0,    0,  48,  48, 1, 0};
      vecs[1] = '{32'h0000_0000, 100, 0, 0, 0, 2, 32'h0,        63, 32'h100,  35, 100, 100, 1, 0};
      vecs[2] = '{32'h0000_0FC0, 32, 0, 0, 0, 2, 32'hFC0,       15, 32'h1000, 15, 32,  32,  1, 0};
      vecs[3] = '{32'h0000_2000, 64, 1, 0, 0, 1, 32'h2000,      63, 32'h0,    0,  64,  64,  1, 0};
      vecs[4] = '{32'h0000_3000, 16, 0, 5, 0, 1, 32'h3000,      15, 32'h0,    0,  4,   16,  0, 1};
      vecs[5] = '{32'h0000_4000, 16, 0, 0, 3, 1, 32'h4000,      15, 32'h0,    0,  3,   16,  0, 0};
      vecs[6] = '{32'h0000_5002, 4,  0, 0, 0, 0, 32'h0,         0,  32'h0,    0,  0,   0,   0, 1};
      vecs[7] = '{32'h0000_8000, 0,  0, 0, 0, 0, 32'h0,         0,  32'h0,    0,  0,   0,   1, 0};
      vecs[8] = '{32'h0000_0FF8, 3,  0, 0, 0, 2, 32'hFF8,       1,  32'h1000, 0,  3,   3,   1, 0};
      vecs[9] = '{32'h0000_0000, 64, 0, 0, 0, 1, 32'h0,         63, 32'h0,    0,  64,  64,  1, 0};

      rstn = 0; i_wire_enable = 0; i_wire_data_next = 1; i_wire_address = 0; i_wire_length = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_state", o_wire_state, 3'd0);
      chk("rst_done", o_wire_done, 0);
      chk("rst_error", o_wire_error, 0);
      chk("rst_arvalid", m_axi_arvalid, 0);
      chk("rst_data_valid", o_wire_data_valid, 0);
      chk("rst_rready", m_axi_rready, 0);
      chk("rst_araddr", m_axi_araddr, 32'h0);
      chk("rst_arlen", m_axi_arlen, 8'h0);
      chk("arsize_const", m_axi_arsize, 3'b010);
      chk("arburst_const", m_axi_arburst, 2'b01);
      rstn = 1;
      step();

      for (int r = 0; r < 10; r++) run_row(r);

      // enable withdrawn while AR is stalled: AR must stay up, then the burst is drained
      clr();
      exp_addr = 32'h6000; i_wire_address = 32'h6000; i_wire_length = 8;
      ar_block = 1; en = 1;
      step(); step();
      chk("b_arvalid", m_axi_arvalid, 1);
      en = 0; bad = 0;
      repeat (3) begin
         step();
         if (!(m_axi_arvalid === 1'b1 && m_axi_araddr === 32'h6000 && m_axi_arlen === 8'd7)) bad++;
      end
      chk("b_ar_stable", bad, 0);
      ar_block = 0; ok = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (o_wire_state == ST_IDLE && !burst_act) begin ok = 1; break; end
      end
      chk("b_idle", ok, 1);
      chk("b_n_ar", n_ar, 1);
      chk("b_hs", n_hs, 8);
      chk("b_fwd", n_fwd, 0);
      chk("b_done", saw_done, 0);
      chk("b_error", saw_err, 0);
      chk("b_rready", rr_bad, 0);

      // close a zero-length session and reopen immediately: one IDLE bubble, then AR
      clr();
      exp_addr = 32'h7000; i_wire_address = 32'h7000; i_wire_length = 0; en = 1;
      step(); step();
      chk("c_done", o_wire_done, 1);
      en = 0;
      step();
      i_wire_length = 2; en = 1;
      step();
      chk("c_bubble_idle", o_wire_state, 3'd0);
      chk("c_bubble_done", o_wire_done, 0);
      step();
      chk("c_arvalid", m_axi_arvalid, 1);
      chk("c_arlen", m_axi_arlen, 8'd1);
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (o_wire_done) begin ok = 1; break; end
      end
      chk("c_second_done", ok, 1);
      chk("c_fwd", n_fwd, 2);
      chk("c_data", data_bad, 0);
      close_session("c");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/painterengine_gpu_memreader.md
Name: painterengine_gpu_memreader

Overview:
AXI4 read master that feeds the display streamer's DMA reader port with 32-bit pixel words from frame memory. Each session is opened by the streamer raising i_wire_enable with a latched address/length. The block splits the request into AXI INCR bursts and forwards beats under the streamer's FIFO back-pressure. It reports completion or error and holds that status until the streamer closes the session.

Parameters:
MAX_BURST, 64, max beats per AXI burst (1..256); DISPLAY_READER_BLOCK_SIZE=64 fits in one burst.
BOUNDARY_BYTES, 4096, AXI address boundary a burst must not cross.

Ports:
i_wire_clock  in  1  system clock
i_wire_resetn  in  1  reset
i_wire_enable  in  1  session open (high) / close (low); driven by streamer o_wire_reader_resetn
i_wire_address  in  32  byte start address, must be 4-byte aligned
i_wire_length  in  32  length in 32-bit words
o_wire_done  out  1  session complete, all words delivered
o_wire_error  out  1  session failed
o_wire_data  out  32  pixel word (= m_axi_rdata)
o_wire_data_valid  out  1  word transferred this cycle
i_wire_data_next  in  1  sink can accept a word (FIFO not full)
o_wire_state  out  3  FSM state, debug
m_axi_araddr  out  32 ; m_axi_arlen  out  8 ; m_axi_arsize  out  3 (const 3'b010) ; m_axi_arburst  out  2 (const INCR 2'b01)
m_axi_arvalid  out  1 ; m_axi_arready  in  1
m_axi_rdata  in  32 ; m_axi_rresp  in  2 ; m_axi_rlast  in  1 ; m_axi_rvalid  in  1 ; m_axi_rready  out  1

Behaviour:
- Reset and clock: i_wire_resetn is asynchronous, active-low; i_wire_clock is the clock. On reset: state IDLE; done, error, arvalid and data_valid = 0; rready = 0; araddr and arlen = 0.
- IDLE: when i_wire_enable = 1, latch address into cur_addr and length into remaining.
  - If address[1:0] != 0, go to ERROR.
  - If length = 0, go to DONE.
  - Otherwise go to ADDR.
- ADDR: beats = min(remaining, MAX_BURST, (BOUNDARY_BYTES - cur_addr[11:0]) >> 2).
  - Drive araddr = cur_addr, arlen = beats-1, arvalid = 1. All are registered and stable until arready.
  - On arvalid & arready: set cur_addr += beats*4, remaining -= beats, beat_cnt = beats, go to DATA.
- DATA: rready = i_wire_data_next (combinational); data_valid = rvalid & i_wire_data_next; data = rdata. On each handshake beat_cnt decrements.
  - rresp != OKAY on any accepted beat: go to ERROR. That beat is not forwarded (data_valid=0); remaining beats are drained.
  - rlast accepted with beat_cnt != 1, or beat_cnt == 1 without rlast: go to ERROR (protocol).
  - Final beat accepted: go to DONE if remaining = 0, else ADDR. There is never more than one outstanding burst.
- DONE: done = 1, held while enable = 1. When enable = 0, clear done and go to IDLE. Done asserts the cycle after the last beat.
- ERROR: error = 1 (sticky), data_valid = 0. If a burst is still outstanding, rready = 1 until its rlast is accepted. Once drained and enable = 0, go to IDLE.
- Enable dropped mid-session:
  - In ADDR before the handshake, arvalid stays asserted until arready (AXI rule), then the block goes to DRAIN.
  - In DATA, go to DRAIN.
  - DRAIN: rready = 1, data_valid = 0; after rlast, go to IDLE. A new enable in DRAIN is ignored until IDLE.
- Enable re-raised in IDLE the same cycle done cleared: it is taken as a new session on the next IDLE cycle (one bubble minimum).
- Arithmetic: remaining and counters are 32-bit unsigned; beats is 9 bits. The 4 KB clip is computed from cur_addr[11:2]. cur_addr wraps modulo 2^32 silently.

Decomposition:
- Shared package painterengine_gpu_pkg: reader state encodings (IDLE=0, ADDR=1, DATA=2, DONE=3, DRAIN=4, ERROR=7), AXI constants (RESP_OKAY=2'b00, BURST_INCR=2'b01, SIZE_4B=3'b010), BOUNDARY_BYTES.
- Sub-module painterengine_gpu_burstcalc: combinational min(remaining, MAX_BURST, words-to-boundary), output registered in the parent on entry to ADDR.

Test Plan:
- addr=0x1000_0000, len=48, arready/rvalid always 1, data_next=1 -> one AR with arlen=47; 48 data_valid pulses; done=1 the cycle after beat 48; done stays 1 until enable=0.
- addr=0x0, len=100, MAX_BURST=64 -> two ARs: araddr 0x0/arlen 63, then araddr 0x100/arlen 35; done after 100 beats.
- addr=0x0000_0FC0, len=32 -> ARs at 0xFC0 arlen=15 and 0x1000 arlen=15; no burst crosses 4 KB.
- len=64, data_next toggled 1/0 every cycle, rvalid=1 -> rready mirrors data_next; exactly 64 data_valid pulses; no word lost or duplicated.
- rresp=SLVERR on beat 5 of a 16-beat burst -> beats 1-4 forwarded; error=1 next cycle; beats 6-16 drained with data_valid=0; IDLE after enable=0.
- enable dropped after beat 3 of a 16-beat burst -> DRAIN accepts remaining 13 beats with data_valid=0; done=0 and error=0; IDLE after rlast. Also: len=0 -> done=1 one cycle after enable with no AR issued.
